// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks in-flight destinations from issue to writeback and drives stall/bubble.
// Define FWD_EN to enable operand forwarding (stalls only for load-use); default build stalls until writeback.
module hazard_scoreboard #(
  parameter int REG_AW     = 4,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_en,
  input  logic [REG_AW-1:0]           id_dst_addr,
  input  logic                        id_dst_we,
  input  logic                        id_is_load,
  input  logic                        flush,
  output logic                        stall,
  output logic                        bubble,
  output logic [NUM_SRC*3-1:0]        fwd_sel,
  output logic                        sb_busy,
  output logic [CNT_W-1:0]            stall_cnt
);

  logic [DEPTH:1]    v_q, we_q, ld_q;
  logic [REG_AW-1:0] dst_q [1:DEPTH];
  logic [CNT_W-1:0]  cnt_q;

  logic [NUM_SRC-1:0] src_stall;
  logic               issue;

`ifdef FWD_EN
  logic [NUM_SRC*3-1:0] fwd_k;
`else
  logic unused_ld;
  assign unused_ld = ^ld_q;
`endif

  // Scan from oldest to youngest so the youngest matching producer overwrites older ones.
  always_comb begin
    src_stall = '0;
`ifdef FWD_EN
    fwd_k = '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (id_valid && id_src_en[i] && v_q[k] && we_q[k] &&
            (dst_q[k] == id_src_addr[i*REG_AW +: REG_AW])) begin
`ifdef FWD_EN
          fwd_k[i*3 +: 3] = 3'(k);
          src_stall[i]    = ld_q[k] && (k < LOAD_STAGE);
`else
          src_stall[i]    = 1'b1;
`endif
        end
      end
    end
  end

  assign stall   = !reset && !flush && (|src_stall);
  assign bubble  = !reset && (stall || (flush && id_valid));
  assign sb_busy = !reset && (|(v_q & we_q));
  assign issue   = id_valid && !stall && !flush;

`ifdef FWD_EN
  assign fwd_sel = (reset || stall) ? '0 : fwd_k;
`else
  assign fwd_sel = '0;
`endif

  assign stall_cnt = cnt_q;

  // Entries shift one stage per cycle; a flush kills the instruction leaving stage 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      we_q  <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        dst_q[k] <= '0;
      end
    end else begin
      v_q[1]   <= issue;
      we_q[1]  <= issue && id_dst_we;
      ld_q[1]  <= issue && id_is_load;
      dst_q[1] <= issue ? id_dst_addr : '0;
      for (int k = 2; k <= DEPTH; k++) begin
        if (flush && (k == 2)) begin
          v_q[k]   <= 1'b0;
          we_q[k]  <= 1'b0;
          ld_q[k]  <= 1'b0;
          dst_q[k] <= '0;
        end else begin
          v_q[k]   <= v_q[k-1];
          we_q[k]  <= we_q[k-1];
          ld_q[k]  <= ld_q[k-1];
          dst_q[k] <= dst_q[k-1];
        end
      end
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
